cla_pipe_adder: RTL and testbench
=================================

Name: cla_pipe_adder

Overview:
- Pipelined, parametrised successor to the combinational carry-lookahead adder.
- Splits an N-bit add/subtract into STAGES segments of LANE bits each. One segment is resolved per clock, and the carry is registered between segments.
- Sustains one operation per cycle.
- Provides a valid/ready handshake on input and output, and a subtract mode, so it drops into streaming datapaths (accumulators, ALU back-ends) without combinational carry paths longer than LANE bits.

Parameters:
- N, 8, operand/result width in bits; must be a multiple of LANE, N >= 2.
- LANE, 4, bits resolved per pipeline stage (CLA group width); 1 <= LANE <= N.
- STAGES, N/LANE, derived localparam, not overridable; pipeline latency in cycles.

Ports:
- clk  input  1  single clock, all state on rising edge.
- rst_n  input  1  synchronous reset, active-low.
- in_valid  input  1  operand set on a/b/cin/sub is valid.
- in_ready  output  1  block accepts an operation this cycle.
- a  input  N  operand A (unsigned or two's complement).
- b  input  N  operand B.
- cin  input  1  carry-in, add mode only.
- sub  input  1  1 = compute a - b, 0 = a + b + cin.
- out_valid  output  1  result on s/cout/ovf is valid.
- out_ready  input  1  downstream consumes result this cycle.
- s  output  N  sum/difference.
- cout  output  1  carry-out of bit N-1 (sub: 1 = no borrow).
- ovf  output  1  signed two's-complement overflow.

Behaviour:
- Reset, sampled on the clk edge while rst_n = 0:
  - all stage valid bits cleared; out_valid = 0; s = 0; cout = 0; ovf = 0.
  - in_ready = 1 during and after reset.
  - Reset mid-operation discards every in-flight operation; nothing partial ever appears on the output.
- Arithmetic:
  - Effective B = sub ? ~b : b.
  - Effective carry-in = sub ? 1 : cin. cin is ignored when sub = 1.
  - Result = a + effB + cin_eff, modulo 2^N.
  - cout = bit N of the full-precision sum.
  - ovf = (a[N-1] == effB[N-1]) && (s[N-1] != a[N-1]).
- Pipeline:
  - Stage k (0..STAGES-1) computes result bits [k*LANE +: LANE] with a LANE-bit lookahead, using the carry registered by stage k-1 (stage 0 uses cin_eff).
  - Unconsumed operand segments and already computed result segments travel with the operation in per-stage registers.
  - ovf is evaluated in the final stage.
- Latency:
  - An operation accepted at edge t (in_valid && in_ready) appears with out_valid = 1 after edge t + STAGES - 1.
  - Outputs are registered; for STAGES = 1 the result is visible the cycle after acceptance.
- Handshake:
  - Global advance enable: adv = !out_valid || out_ready. in_ready = adv.
  - When adv = 1, every stage shifts forward one position and a bubble enters if in_valid = 0.
  - When adv = 0, all stages hold and s/cout/ovf/out_valid stay stable.
  - out_valid never drops without out_ready = 1.
  - Bubbles are not compressed: throughput is 1 op/cycle when out_ready is held high.
  - a/b/cin/sub are don't-care when in_valid = 0 and must not affect outputs.
- Simultaneous events:
  - Accept and output consume in the same cycle are legal and produce no loss or duplication.
  - rst_n = 0 overrides the handshake in the same cycle.
- Ordering: results emerge strictly in acceptance order. No reordering and no drops.
- Boundaries:
  - Full-carry propagation across all segments (e.g. all-ones + 1) must be exact.
  - With LANE = N the block degenerates to a single registered CLA stage.

Test Plan:
- N=8, LANE=4, out_ready=1: a=0xFF, b=0x01, cin=0, sub=0 -> exactly 2 cycles later out_valid=1, s=0x00, cout=1, ovf=0.
- N=8, LANE=4, signed overflow and subtract, issued back to back:
  - a=0x7F + b=0x01 -> s=0x80, cout=0, ovf=1.
  - a=0x05 - b=0x07 -> s=0xFE, cout=0, ovf=0.
  - a=0x80 - b=0x01 -> s=0x7F, cout=1, ovf=1.
  - Results appear on consecutive cycles.
- Back-pressure, N=8:
  - Issue 3 ops (a,b) = (1,2), (3,4), (5,6) on consecutive cycles with out_ready=0.
  - Expected: in_ready falls once the first result reaches the output; out_valid holds s=0x03 stable.
  - Then out_ready=1 -> s sequence 0x03, 0x07, 0x0B, none lost or duplicated.
- Reset mid-flight:
  - Accept two ops, then assert rst_n=0 for 1 cycle.
  - Expected: out_valid=0, s=0, cout=0, ovf=0 afterwards; no stale result ever appears; in_ready=1.
- Streaming sweep, N=8, LANE=4 and N=2, LANE=1, in_valid=1 and out_ready=1 for 32 cycles:
  - N=8: a += 3, b += 5 each cycle, cin=0.
  - N=2: a += 1 every cycle, b += 1 every 4 cycles.
  - Every output matches a reference model at latency STAGES, 1 result per cycle.
- Random with random out_ready/in_valid (both ~50%), N=16, LANE=4, 1000 ops, mixed sub/cin -> scoreboard exact match on s/cout/ovf, in-order, output stable while stalled.

Source files
------------

// File: rtl/cla_pipe_adder.sv
`default_nettype none
// ============================================================================
//  Module      : cla_pipe_adder
//  Description : Pipelined carry-lookahead adder/subtractor. The N-bit word is
//                resolved LANE bits per clock over N/LANE stages. Inter-stage
//                carries are registered. A valid/ready handshake is provided
//                on both sides, and all stages stall together.
//  Revision    : 1.0 - initial release
// ============================================================================
module cla_pipe_adder #(
  parameter int N    = 8,
  parameter int LANE = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] s,
  output logic         cout,
  output logic         ovf
);

  localparam int           STAGES      = N / LANE;
  localparam logic [N-1:0] C_LANE_ONES = N'({LANE{1'b1}});

  // Each stage register packs {operand a, effective operand b, partial sum}.
  // Segments already consumed are carried along so a single array serves
  // every stage, including the last one which drives the result port.
  logic [3*N-1:0]    r_d [STAGES];
  logic [STAGES-1:0] r_v;
  logic [STAGES-1:0] r_c;
  logic              r_ovf;

  logic [N-1:0]      w_a_in  [STAGES];
  logic [N-1:0]      w_b_in  [STAGES];
  logic [N-1:0]      w_s_in  [STAGES];
  logic [N-1:0]      w_s_nxt [STAGES];
  logic [LANE:0]     w_lane  [STAGES];
  logic [STAGES-1:0] w_v_in;
  logic [STAGES-1:0] w_c_in;
  logic [STAGES-1:0] w_c_out;
  logic [N-1:0]      w_b_eff;
  logic              w_c_eff;
  logic              w_adv;
  logic              w_ovf_nxt;

  // One LANE-bit lookahead group: generate/propagate per bit, carries from
  // the group carry-in, returns {group carry-out, sum bits}.
  function automatic logic [LANE:0] cla_lane(input logic [LANE-1:0] x,
                                             input logic [LANE-1:0] y,
                                             input logic            c);
    logic [LANE-1:0] g;
    logic [LANE-1:0] p;
    logic [LANE:0]   cc;
    g     = x & y;
    p     = x ^ y;
    cc[0] = c;
    for (int i = 0; i < LANE; i++) begin
      cc[i+1] = g[i] | (p[i] & cc[i]);
    end
    return {cc[LANE], p ^ cc[LANE-1:0]};
  endfunction

  // Subtraction is a + ~b + 1; cin only matters in add mode.
  assign w_b_eff  = sub ? ~b : b;
  assign w_c_eff  = sub | cin;

  // The whole pipe moves as one unit whenever the output slot is free.
  assign w_adv    = !out_valid || out_ready;
  assign in_ready = !rst_n || w_adv;

  genvar k;
  generate
    for (k = 0; k < STAGES; k++) begin : g_stage
      if (k == 0) begin : g_head
        assign w_v_in[k] = in_valid;
        assign w_a_in[k] = a;
        assign w_b_in[k] = w_b_eff;
        assign w_c_in[k] = w_c_eff;
        assign w_s_in[k] = '0;
      end else begin : g_body
        assign w_v_in[k] = r_v[k-1];
        assign w_a_in[k] = r_d[k-1][3*N-1:2*N];
        assign w_b_in[k] = r_d[k-1][2*N-1:N];
        assign w_c_in[k] = r_c[k-1];
        assign w_s_in[k] = r_d[k-1][N-1:0];
      end
      assign w_lane[k]  = cla_lane(w_a_in[k][k*LANE +: LANE],
                                   w_b_in[k][k*LANE +: LANE],
                                   w_c_in[k]);
      assign w_c_out[k] = w_lane[k][LANE];
      // Splice this stage's segment into the travelling partial sum.
      assign w_s_nxt[k] = (w_s_in[k] & ~(C_LANE_ONES << (k*LANE)))
                        | (N'(w_lane[k][LANE-1:0]) << (k*LANE));
    end
  endgenerate

  // Signed overflow needs the final sign bit, so it is formed in the last stage.
  assign w_ovf_nxt = (w_a_in[STAGES-1][N-1] == w_b_in[STAGES-1][N-1]) &&
                     (w_s_nxt[STAGES-1][N-1] != w_a_in[STAGES-1][N-1]);

  // Pipeline registers: reset flushes everything, bubbles keep stale data so
  // don't-care inputs never reach the result port.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_v   <= '0;
      r_c   <= '0;
      r_ovf <= 1'b0;
      for (int j = 0; j < STAGES; j++) begin
        r_d[j] <= '0;
      end
    end else if (w_adv) begin
      r_v <= w_v_in;
      for (int j = 0; j < STAGES; j++) begin
        if (w_v_in[j]) begin
          r_d[j] <= {w_a_in[j], w_b_in[j], w_s_nxt[j]};
          r_c[j] <= w_c_out[j];
        end
      end
      if (w_v_in[STAGES-1]) begin
        r_ovf <= w_ovf_nxt;
      end
    end
  end

  assign out_valid = r_v[STAGES-1];
  assign s         = r_d[STAGES-1][N-1:0];
  assign cout      = r_c[STAGES-1];
  assign ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_cla_pipe_adder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cla_pipe_adder
//  Description : Directed and randomised checks of cla_pipe_adder in the
//                8/4, 2/1, 16/4 and 8/8 (single stage) configurations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cla_pipe_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   n_tests;
  int   n_fail;

  // N=8, LANE=4
  logic       iv8, ir8, ov8, ordy8, ci8, sb8, co8, of8;
  logic [7:0] a8, b8, s8;
  // N=2, LANE=1
  logic       iv2, ir2, ov2, ordy2, ci2, sb2, co2, of2;
  logic [1:0] a2, b2, s2;
  // N=16, LANE=4
  logic        iv16, ir16, ov16, ordy16, ci16, sb16, co16, of16;
  logic [15:0] a16, b16, s16;
  // N=8, LANE=8
  logic       ivf, irf, ovf_v, ordyf, cif, sbf, cof, off;
  logic [7:0] af, bf, sf;

  cla_pipe_adder #(.N(8), .LANE(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .cin(ci8), .sub(sb8), .out_valid(ov8), .out_ready(ordy8), .s(s8),
    .cout(co8), .ovf(of8));

  cla_pipe_adder #(.N(2), .LANE(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2), .a(a2), .b(b2),
    .cin(ci2), .sub(sb2), .out_valid(ov2), .out_ready(ordy2), .s(s2),
    .cout(co2), .ovf(of2));

  cla_pipe_adder #(.N(16), .LANE(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
    .cin(ci16), .sub(sb16), .out_valid(ov16), .out_ready(ordy16), .s(s16),
    .cout(co16), .ovf(of16));

  cla_pipe_adder #(.N(8), .LANE(8)) dutf (
    .clk(clk), .rst_n(rst_n), .in_valid(ivf), .in_ready(irf), .a(af), .b(bf),
    .cin(cif), .sub(sbf), .out_valid(ovf_v), .out_ready(ordyf), .s(sf),
    .cout(cof), .ovf(off));

  // Reference arithmetic for width n (<= 16): returns {ovf, cout, s[15:0]}.
  function automatic logic [17:0] model(input int n, input logic [15:0] x,
                                        input logic [15:0] y, input logic c,
                                        input logic sb);
    logic [16:0] sum;
    logic [15:0] mask, eb, r;
    logic        co, ov;
    mask = 16'((17'h1 << n) - 17'h1);
    eb   = (sb ? ~y : y) & mask;
    sum  = {1'b0, x & mask} + {1'b0, eb} + {16'h0, (sb | c)};
    r    = sum[15:0] & mask;
    co   = sum[n];
    ov   = (x[n-1] == eb[n-1]) && (r[n-1] != x[n-1]);
    return {ov, co, r};
  endfunction

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({ov8, s8, co8, of8} !== 11'h0) begin
      n_fail++; $display("FAIL reset_outputs8: got v=%b s=%h c=%b o=%b want all 0", ov8, s8, co8, of8);
    end
    n_tests++;
    if ({ov2, ov16, ovf_v} !== 3'b000) begin
      n_fail++; $display("FAIL reset_valid_others: got %b want 000", {ov2, ov16, ovf_v});
    end
    n_tests++;
    if (ir8 !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready_during: got %b want 1", ir8);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({ir8, ov8, s8} !== {1'b1, 1'b0, 8'h00}) begin
      n_fail++; $display("FAIL reset_after: got ir=%b v=%b s=%h want ir=1 v=0 s=00", ir8, ov8, s8);
    end
  endtask

  task automatic test_carry_chain;
    iv8 = 1'b1; a8 = 8'hFF; b8 = 8'h01; ci8 = 1'b0; sb8 = 1'b0; ordy8 = 1'b1;
    #1;
    n_tests++;
    if (ir8 !== 1'b1) begin
      n_fail++; $display("FAIL carry_accept: in_ready got %b want 1", ir8);
    end
    @(negedge clk);
    iv8 = 1'b0; a8 = 8'h5A; b8 = 8'hA5;
    n_tests++;
    if (ov8 !== 1'b0) begin
      n_fail++; $display("FAIL carry_early: out_valid got %b want 0", ov8);
    end
    @(negedge clk);
    n_tests++;
    if ({ov8, of8, co8, s8} !== {1'b1, 1'b0, 1'b1, 8'h00}) begin
      n_fail++; $display("FAIL carry_result: got v=%b o=%b c=%b s=%h want v=1 o=0 c=1 s=00", ov8, of8, co8, s8);
    end
    @(negedge clk);
    n_tests++;
    if (ov8 !== 1'b0) begin
      n_fail++; $display("FAIL carry_single: out_valid got %b want 0", ov8);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] ta [3];
    logic [7:0] tb_ [3];
    logic       tsub [3];
    logic [7:0] es [3];
    logic       ec [3];
    logic       eo [3];
    ta = '{8'h7F, 8'h05, 8'h80}; tb_ = '{8'h01, 8'h07, 8'h01}; tsub = '{1'b0, 1'b1, 1'b1};
    es = '{8'h80, 8'hFE, 8'h7F}; ec = '{1'b0, 1'b0, 1'b1};     eo = '{1'b1, 1'b0, 1'b1};
    ordy8 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i >= 2) begin
        n_tests++;
        if ({ov8, of8, co8, s8} !== {1'b1, eo[i-2], ec[i-2], es[i-2]}) begin
          n_fail++; $display("FAIL b2b_op%0d: got v=%b o=%b c=%b s=%h want v=1 o=%b c=%b s=%h",
                             i-2, ov8, of8, co8, s8, eo[i-2], ec[i-2], es[i-2]);
        end
      end
      if (i < 3) begin
        iv8 = 1'b1; a8 = ta[i]; b8 = tb_[i]; sb8 = tsub[i]; ci8 = tsub[i];
      end else begin
        iv8 = 1'b0; sb8 = 1'b0; ci8 = 1'b0;
      end
      @(negedge clk);
    end
    n_tests++;
    if (ov8 !== 1'b0) begin
      n_fail++; $display("FAIL b2b_drain: out_valid got %b want 0", ov8);
    end
  endtask

  task automatic test_backpressure;
    ordy8 = 1'b0; sb8 = 1'b0; ci8 = 1'b0;
    iv8 = 1'b1; a8 = 8'd1; b8 = 8'd2;
    @(negedge clk);
    a8 = 8'd3; b8 = 8'd4;
    @(negedge clk);
    a8 = 8'd5; b8 = 8'd6;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_tests++;
      if ({ir8, ov8, s8} !== {1'b0, 1'b1, 8'h03}) begin
        n_fail++; $display("FAIL bp_stall%0d: got ir=%b v=%b s=%h want ir=0 v=1 s=03", i, ir8, ov8, s8);
      end
      @(negedge clk);
    end
    ordy8 = 1'b1;
    #1;
    n_tests++;
    if ({ir8, ov8, s8} !== {1'b1, 1'b1, 8'h03}) begin
      n_fail++; $display("FAIL bp_release: got ir=%b v=%b s=%h want ir=1 v=1 s=03", ir8, ov8, s8);
    end
    @(negedge clk);
    iv8 = 1'b0;
    n_tests++;
    if ({ov8, s8} !== {1'b1, 8'h07}) begin
      n_fail++; $display("FAIL bp_second: got v=%b s=%h want v=1 s=07", ov8, s8);
    end
    @(negedge clk);
    n_tests++;
    if ({ov8, s8} !== {1'b1, 8'h0B}) begin
      n_fail++; $display("FAIL bp_third: got v=%b s=%h want v=1 s=0b", ov8, s8);
    end
    @(negedge clk);
    n_tests++;
    if (ov8 !== 1'b0) begin
      n_fail++; $display("FAIL bp_no_dup: out_valid got %b want 0", ov8);
    end
  endtask

  task automatic test_reset_midflight;
    ordy8 = 1'b1; sb8 = 1'b0; ci8 = 1'b0;
    iv8 = 1'b1; a8 = 8'h11; b8 = 8'h22;
    @(negedge clk);
    a8 = 8'h33; b8 = 8'h44;
    @(negedge clk);
    iv8 = 1'b0; ordy8 = 1'b0; rst_n = 1'b0;
    #1;
    n_tests++;
    if (ir8 !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid_ready: in_ready got %b want 1", ir8);
    end
    @(negedge clk);
    rst_n = 1'b1; ordy8 = 1'b1;
    #1;
    n_tests++;
    if ({ir8, ov8, s8, co8, of8} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL rst_mid_clear: got ir=%b v=%b s=%h c=%b o=%b want ir=1 v=0 s=00 c=0 o=0",
                         ir8, ov8, s8, co8, of8);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_tests++;
      if ({ov8, s8} !== 9'h000) begin
        n_fail++; $display("FAIL rst_mid_stale%0d: got v=%b s=%h want v=0 s=00", i, ov8, s8);
      end
    end
  endtask

  task automatic test_stream8;
    logic [7:0]  ta [32];
    logic [7:0]  tb_ [32];
    logic [17:0] e;
    ordy8 = 1'b1; ci8 = 1'b0; sb8 = 1'b0;
    for (int i = 0; i < 34; i++) begin
      if (i >= 2) begin
        e = model(8, {8'h00, ta[i-2]}, {8'h00, tb_[i-2]}, 1'b0, 1'b0);
        n_tests++;
        if ({ov8, of8, co8, s8} !== {1'b1, e[17], e[16], e[7:0]}) begin
          n_fail++; $display("FAIL stream8_%0d: got v=%b o=%b c=%b s=%h want v=1 o=%b c=%b s=%h",
                             i-2, ov8, of8, co8, s8, e[17], e[16], e[7:0]);
        end
      end
      if (i < 32) begin
        ta[i] = 8'h10 + 8'(3 * i);
        tb_[i] = 8'hF0 + 8'(5 * i);
        iv8 = 1'b1; a8 = ta[i]; b8 = tb_[i];
      end else begin
        iv8 = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_stream2;
    logic [1:0]  ta [32];
    logic [1:0]  tb_ [32];
    logic [17:0] e;
    ordy2 = 1'b1; ci2 = 1'b0; sb2 = 1'b0;
    for (int i = 0; i < 34; i++) begin
      if (i >= 2) begin
        e = model(2, {14'h0, ta[i-2]}, {14'h0, tb_[i-2]}, 1'b0, 1'b0);
        n_tests++;
        if ({ov2, of2, co2, s2} !== {1'b1, e[17], e[16], e[1:0]}) begin
          n_fail++; $display("FAIL stream2_%0d: got v=%b o=%b c=%b s=%h want v=1 o=%b c=%b s=%h",
                             i-2, ov2, of2, co2, s2, e[17], e[16], e[1:0]);
        end
      end
      if (i < 32) begin
        ta[i] = 2'(i);
        tb_[i] = 2'(i / 4);
        iv2 = 1'b1; a2 = ta[i]; b2 = tb_[i];
      end else begin
        iv2 = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_lane_full;
    ordyf = 1'b1; cif = 1'b0; sbf = 1'b0;
    ivf = 1'b1; af = 8'hFF; bf = 8'h01;
    @(negedge clk);
    af = 8'h7F; bf = 8'h01;
    n_tests++;
    if ({ovf_v, off, cof, sf} !== {1'b1, 1'b0, 1'b1, 8'h00}) begin
      n_fail++; $display("FAIL full_carry: got v=%b o=%b c=%b s=%h want v=1 o=0 c=1 s=00", ovf_v, off, cof, sf);
    end
    @(negedge clk);
    ivf = 1'b0;
    n_tests++;
    if ({ovf_v, off, cof, sf} !== {1'b1, 1'b1, 1'b0, 8'h80}) begin
      n_fail++; $display("FAIL full_ovf: got v=%b o=%b c=%b s=%h want v=1 o=1 c=0 s=80", ovf_v, off, cof, sf);
    end
  endtask

  task automatic test_random;
    logic [17:0] q [$];
    logic [17:0] e;
    logic [17:0] prev_out;
    logic        prev_stall;
    int          acc;
    int          cyc;
    acc = 0; cyc = 0; prev_stall = 1'b0; prev_out = '0;
    while ((acc < 1000 || q.size() > 0) && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (prev_stall) begin
        n_tests++;
        if ({ov16, of16, co16, s16} !== {1'b1, prev_out}) begin
          n_fail++; $display("FAIL rand_stable: got v=%b %h want v=1 %h", ov16, {of16, co16, s16}, prev_out);
        end
      end
      ordy16 = 1'($urandom_range(0, 1));
      iv16   = (acc < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
      a16    = 16'($urandom);
      b16    = 16'($urandom);
      ci16   = 1'($urandom_range(0, 1));
      sb16   = 1'($urandom_range(0, 1));
      #1;
      n_tests++;
      if (ir16 !== (!ov16 || ordy16)) begin
        n_fail++; $display("FAIL rand_ready: got %b want %b", ir16, (!ov16 || ordy16));
      end
      if (ov16 && ordy16) begin
        n_tests++;
        if (q.size() == 0) begin
          n_fail++; $display("FAIL rand_spurious: got s=%h want no output", s16);
        end else begin
          e = q.pop_front();
          if ({of16, co16, s16} !== e) begin
            n_fail++; $display("FAIL rand_result: got %h want %h", {of16, co16, s16}, e);
          end
        end
      end
      if (iv16 && (!ov16 || ordy16)) begin
        q.push_back(model(16, a16, b16, ci16, sb16));
        acc++;
      end
      prev_stall = ov16 && !ordy16;
      prev_out   = {of16, co16, s16};
    end
    n_tests++;
    if (cyc >= 20000) begin
      n_fail++; $display("FAIL rand_timeout: got %0d accepted %0d pending want 1000 accepted 0 pending", acc, q.size());
    end
    iv16 = 1'b0; ordy16 = 1'b1;
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    rst_n = 1'b0;
    iv8 = 1'b0; ordy8 = 1'b1; a8 = '0; b8 = '0; ci8 = 1'b0; sb8 = 1'b0;
    iv2 = 1'b0; ordy2 = 1'b1; a2 = '0; b2 = '0; ci2 = 1'b0; sb2 = 1'b0;
    iv16 = 1'b0; ordy16 = 1'b1; a16 = '0; b16 = '0; ci16 = 1'b0; sb16 = 1'b0;
    ivf = 1'b0; ordyf = 1'b1; af = '0; bf = '0; cif = 1'b0; sbf = 1'b0;
    test_reset();
    test_carry_chain();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    test_stream8();
    test_stream2();
    test_lane_full();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
